// File: rtl/wb_rr_arbiter_4x1.sv
// Round-robin 4:1 write-back arbiter with a one-entry valid/ready output register.
// Define WB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest, no pointer).
module wb_rr_arbiter_4x1 #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [1:0] RESET_PTR  = 2'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req_valid,
    output logic [3:0]            req_ready,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    output logic [1:0]            select,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic [1:0]            out_src
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              scan_base;
    logic [1:0]              scan_idx;
    logic [1:0]              winner;
    logic                    found;
    logic                    load;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   win_data;

`ifdef WB_ARB_FIXED_PRIO_EN
    assign scan_base = 2'd0;
`else
    logic [1:0] ptr;

    // Pointer moves only on an accept, to the slot just after the winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= RESET_PTR;
        end else if (accept) begin
            ptr <= winner + 2'd1;
        end
    end

    assign scan_base = ptr;
`endif

    always_comb begin
        winner   = 2'd0;
        found    = 1'b0;
        scan_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = scan_base + 2'(k);
            if (!found && req_valid[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    assign load      = (state == EMPTY) || out_ready;
    assign req_ready = (!reset && load && found) ? (4'b0001 << winner) : 4'b0000;
    assign accept    = |req_ready;
    assign select    = winner;
    assign out_valid = (state == FULL);

    always_comb begin
        win_data = in0;
        case (winner)
            2'd0:    win_data = in0;
            2'd1:    win_data = in1;
            2'd2:    win_data = in2;
            default: win_data = in3;
        endcase
    end

    // A drain and a fresh accept on the same edge keep the register full.
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = FULL;
        end else if ((state == FULL) && out_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out     <= '0;
            out_src <= 2'd0;
        end else if (accept) begin
            out     <= win_data;
            out_src <= winner;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter_4x1.sv
// Directed self-checking bench for wb_rr_arbiter_4x1 (round-robin or fixed priority build).
module tb_wb_rr_arbiter_4x1;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] in3;
    logic [1:0]  select;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [1:0]  out_src;

    int checkCount;
    int errorCount;

    wb_rr_arbiter_4x1 #(.DATA_WIDTH(32), .RESET_PTR(2'd0)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic ready);
        req_valid = valid;
        out_ready = ready;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b1;
        req_valid  = 4'b0000;
        out_ready  = 1'b0;
        in0        = 32'hA0;
        in1        = 32'hA1;
        in2        = 32'hA2;
        in3        = 32'hA3;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Idle after reset
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out", out, 32'd0);
        checkOutput("rst_select", 32'(select), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);

`ifndef WB_ARB_FIXED_PRIO_EN
        // All four requesting with a free sink: one word per cycle in rotation
        applyStimulus(4'b1111, 1'b1);
        checkOutput("rr_first_ready", 32'(req_ready), 32'b0001);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("rr_out", out, 32'hA0 + 32'(k));
            checkOutput("rr_src", 32'(out_src), 32'(k));
            checkOutput("rr_valid", 32'(out_valid), 32'd1);
            checkOutput("rr_next_sel", 32'(select), 32'((k + 1) % 4));
        end

        // Pointer wrapped 3->0: req 0 then req 3
        applyStimulus(4'b1001, 1'b1);
        checkOutput("wrap_sel0", 32'(select), 32'd0);
        tick();
        checkOutput("wrap_src0", 32'(out_src), 32'd0);
        checkOutput("wrap_sel3", 32'(select), 32'd3);
        checkOutput("wrap_ready3", 32'(req_ready), 32'b1000);
        tick();
        checkOutput("wrap_src3", 32'(out_src), 32'd3);
        checkOutput("wrap_out3", out, 32'hA3);
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("drain_valid", 32'(out_valid), 32'd0);
        checkOutput("drain_hold_out", out, 32'hA3);
        checkOutput("drain_hold_src", 32'(out_src), 32'd3);
`else
        // Fixed priority: req 0 always beats req 1
        applyStimulus(4'b0011, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("fix_ready", 32'(req_ready), 32'b0001);
            tick();
            checkOutput("fix_src", 32'(out_src), 32'd0);
            checkOutput("fix_out", out, 32'hA0);
            checkOutput("fix_valid", 32'(out_valid), 32'd1);
        end
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("fix_drain", 32'(out_valid), 32'd0);
`endif

        // Single requester into a stalled sink
        in2 = 32'hDEADBEEF;
        applyStimulus(4'b0100, 1'b0);
        checkOutput("st_accept_ready", 32'(req_ready), 32'b0100);
        tick();
        for (int k = 0; k < 3; k++) begin
            checkOutput("st_valid", 32'(out_valid), 32'd1);
            checkOutput("st_out", out, 32'hDEADBEEF);
            checkOutput("st_src", 32'(out_src), 32'd2);
            checkOutput("st_no_ready", 32'(req_ready), 32'd0);
            tick();
        end
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("st_drain_valid", 32'(out_valid), 32'd0);
        checkOutput("st_drain_out", out, 32'hDEADBEEF);

        // Reset while full with requests pending
        applyStimulus(4'b0010, 1'b0);
        tick();
        checkOutput("mr_src", 32'(out_src), 32'd1);
        checkOutput("mr_out", out, 32'hA1);
        applyStimulus(4'b1111, 1'b0);
        checkOutput("mr_stall_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("mr_reset_ready", 32'(req_ready), 32'd0);
        tick();
        checkOutput("mr_valid", 32'(out_valid), 32'd0);
        checkOutput("mr_out_cleared", out, 32'd0);
        checkOutput("mr_src_cleared", 32'(out_src), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("mr_ptr_sel", 32'(select), 32'd0);
        applyStimulus(4'b1111, 1'b1);
        tick();
        checkOutput("mr_after_src", 32'(out_src), 32'd0);
        checkOutput("mr_after_valid", 32'(out_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
